pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 163 ++++++++++++++++
 tb/tb_pipe_skid_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid-buffered pipeline register for an in-order
// pipeline stage boundary (e.g. IF/ID). It carries a payload plus a control
// bundle and presents a NOP bubble whenever it holds nothing.
//
// in_ready comes straight from a flop, so there is no combinational path
// from out_ready to in_ready. The skid entry catches the one word that
// upstream may still push in the cycle a stall first appears.
//
// Optional feature: define PIPE_STALL_CNT_EN to build a saturating counter of
// downstream-stall cycles. The counter is visible on stall_cnt and is cleared
// only by rst. When the macro is undefined, stall_cnt is tied to zero and no
// counter logic exists.
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | nothing held, bubble presented, occupancy 0
// ONE   | main register holds the presented entry, occupancy 1
// FULL  | main presented, skid holds the next entry, in_ready low, occupancy 2

module pipe_skid_reg #(
    parameter int                 DATA_W      = 64,
    parameter int                 CTRL_W      = 16,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = {32'h0, 32'h00000013},
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The state encoding equals the entry count, so occupancy is the state itself.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              in_ready_r;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_fire  = in_valid & in_ready_r;
    assign out_fire = out_valid & out_ready;

    // Next-state and register-load selection; flush overrides every handshake.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State and registered in_ready; rst wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_r <= (state_nxt != FULL);
        end
    end

    // Main register: loads from input or promotes the skid entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_data <= BUBBLE_DATA;
            main_ctrl <= '0;
        end else if (load_main_in) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
        end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
        end
    end

    // Skid register: catches the word accepted while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            skid_data <= BUBBLE_DATA;
            skid_ctrl <= '0;
        end else if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_data : BUBBLE_DATA;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign occupancy = state;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating count of cycles where a presented entry is held off downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_r != '1)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed tests for pipe_skid_reg. Inputs change 1 ns
// after a rising edge, and outputs are sampled at that same point.

module tb_pipe_skid_reg;

    localparam int          DATA_W = 64;
    localparam int          CTRL_W = 16;
    localparam int          CNT_W  = 4;
    localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0013;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_DATA(BUBBLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL reset_out_data: got %h want %h", out_data, BUBBLE); end
        checks++; if (out_ctrl !== 16'h0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_single();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h1000_0000_0093; in_ctrl = 16'h00a5;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 64'h1000_0000_0093) begin errors++; $display("FAIL single_data: got %h want 100000000093", out_data); end
        checks++; if (out_ctrl !== 16'h00a5) begin errors++; $display("FAIL single_ctrl: got %h want 00a5", out_ctrl); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL single_occ: got %0d want 1", occupancy); end
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL single_drain_occ: got %0d want 0", occupancy); end
        checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL single_drain_data: got %h want %h", out_data, BUBBLE); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 64'h200 + 64'(i); in_ctrl = 16'(i);
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 64'h200 + 64'(i)) begin
                errors++; $display("FAIL b2b_data[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_data, 64'h200 + 64'(i)); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hA; in_ctrl = 16'h1;
        step();
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL skid_a: got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, in_ready); end
        in_data = 64'hB; in_ctrl = 16'h2;
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_b_occ: got %0d want 2", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_b_rdy: got %b want 0", in_ready); end
        in_data = 64'hC; in_ctrl = 16'h3;
        step();
        checks++; if (occupancy !== 2'd2 || out_data !== 64'hA || out_ctrl !== 16'h1) begin
            errors++; $display("FAIL skid_hold: got occ=%0d %h/%h want occ=2 a/1", occupancy, out_data, out_ctrl); end
        out_ready = 1'b1;
        checks++; if (out_data !== 64'hA) begin errors++; $display("FAIL skid_out_a: got %h want a", out_data); end
        step();
        checks++; if (out_data !== 64'hB || out_ctrl !== 16'h2) begin errors++; $display("FAIL skid_out_b: got %h/%h want b/2", out_data, out_ctrl); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_rdy_back: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 64'hC) begin errors++; $display("FAIL skid_out_c: got v=%b %h want v=1 c", out_valid, out_data); end
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL skid_drain: got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hD; step();
        in_data = 64'hE; step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
        flush = 1'b1; in_data = 64'hF;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== BUBBLE) begin errors++; $display("FAIL flush_out: got v=%b %h want v=0 %h", out_valid, out_data, BUBBLE); end
        checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got occ=%0d rdy=%b want 0/1", occupancy, in_ready); end
        out_ready = 1'b1;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_leak: got v=%b %h want v=0", out_valid, out_data); end
        // Flush from ONE while the input handshake would fire: input must be discarded.
        in_valid = 1'b1; in_data = 64'h11; step();
        flush = 1'b1; in_data = 64'h12; step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_one: got v=%b occ=%0d want 0/0", out_valid, occupancy); end
    endtask

    task automatic test_stall_cnt();
        do_reset();
        in_valid = 1'b1; in_data = 64'h55; step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
`ifdef PIPE_STALL_CNT_EN
        checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL stall_cnt_5: got %0d want 5", stall_cnt); end
        for (int i = 0; i < 15; i++) step();
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_cnt_sat: got %0d want 15", stall_cnt); end
        flush = 1'b1; step(); flush = 1'b0;
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_cnt_flush: got %0d want 15", stall_cnt); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stall_cnt_rst: got %0d want 0", stall_cnt); end
`else
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stall_cnt_off: got %0d want 0", stall_cnt); end
        flush = 1'b1; step(); flush = 1'b0;
`endif
    endtask

    task automatic test_rst_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h77; in_ctrl = 16'h7; step();
        in_data = 64'h78; step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rf_pre_occ: got %0d want 2", occupancy); end
        rst = 1'b1; flush = 1'b1; in_data = 64'h79;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== BUBBLE || out_ctrl !== 16'h0) begin
            errors++; $display("FAIL rf_out: got v=%b %h/%h want v=0 %h/0", out_valid, out_data, out_ctrl, BUBBLE); end
        checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL rf_state: got occ=%0d rdy=%b cnt=%0d want 0/1/0", occupancy, in_ready, stall_cnt); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h80; in_ctrl = 16'h8; step();
        in_valid = 1'b0;
        checks++; if (out_data !== 64'h80 || occupancy !== 2'd1) begin errors++; $display("FAIL rf_recover: got %h occ=%0d want 80 occ=1", out_data, occupancy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_skid();
        test_flush();
        test_stall_cnt();
        test_rst_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
